adder_bist_ctrl: RTL
====================

// Module: adder_bist_ctrl
// PURPOSE
//  On-chip stimulus/checker for the N-logic adder. It is the driving end of the adder's operand
//  interface. After a Start pulse it sweeps four operand phases, applying each (A,B) pair with
//  Cin=1 and then Cin=0. For every vector it samples S/Cout after a settle window and compares
//  them against a behavioural sum. It reports Pass/Fail, an error count and the first failing
//  vector. It sits beside the adder macro and is driven by the test-mode controller.
// PARAMETERS
//  WIDTH     32     operand width
//  SPAN      500    values swept per operand per phase (>=2)
//  MID_BASE  65530  start value of the mid-range phase
//  SETTLE    4      cycles each vector is held before sampling (>=1)
// PORTS
//  Clk      in   1        clock, rising edge
//  Rst_n    in   1        async active-low reset
//  Start    in   1        1-cycle run request
//  Busy     out  1        run in progress
//  Done     out  1        run finished; held until next accepted Start
//  Pass     out  1        valid when Done: 1 = zero mismatches
//  Phase    out  2        current sweep phase
//  A,B      out  WIDTH    operands to adder under test
//  Cin      out  1        carry-in to adder under test
//  S        in   WIDTH    adder sum
//  Cout     in   1        adder carry-out
//  ErrCnt   out  16       mismatch count, saturates at 16'hFFFF
//  FailA,FailB out WIDTH  operands of first mismatch
//  FailCin  out  1        Cin of first mismatch
//  FailS    out  WIDTH+1  {Cout,S} observed at first mismatch
// BEHAVIOUR
//  Reset: FSM=IDLE, all outputs 0 (Pass=0). Reset mid-run aborts immediately; no partial result kept.
//  FSM: IDLE -(Start)-> APPLY -(SETTLE cycles)-> CHECK -> APPLY (next vector) | DONE (last vector).
//   DONE -(Start)-> APPLY. Start is ignored while Busy.
//  Accepted Start clears ErrCnt, the Fail* registers and Pass. Busy=1 from the next cycle.
//  Each vector costs SETTLE+1 cycles: SETTLE in APPLY, 1 in CHECK. A/B/Cin are stable throughout.
//  CHECK: expected = {1'b0,A}+{1'b0,B}+Cin, computed 33-bit with no truncation.
//   On mismatch with {Cout,S}: ErrCnt++ (saturating). The first mismatch of the run loads Fail*.
//  Vector order: for each A, for each B, Cin=1 then Cin=0. B wraps to its phase start when A advances.
//   Phase0: A,B = MID_BASE .. MID_BASE+SPAN-1, ascending.
//   Phase1: A,B = 0 .. SPAN-1, ascending.
//   Phase2: A,B = 2^WIDTH-1 descending SPAN values (i.e. -1 .. -SPAN).
//   Phase3: A = 1 .. SPAN ascending; B = -1 .. -SPAN descending.
//  Total vectors 8*SPAN^2. Operand arithmetic is modulo 2^WIDTH.
//  After CHECK of the last vector: Busy=0, Done=1, Pass=(ErrCnt==0). A/B/Cin hold their last values.
//  Simultaneous Start and last CHECK: Start ignored (Busy still 1).
// CONFIGURATION
//  ADDER_BIST_STOP_ON_FAIL_EN defined:
//   - the first mismatch ends the run in that CHECK cycle: DONE, Pass=0, ErrCnt=1;
//   - Phase, A, B and Cin freeze on the failing vector.
//  Undefined: the run always completes all vectors and ErrCnt counts every mismatch.
// TESTING  (SPAN=4, SETTLE=4, MID_BASE=65530 -> 128 vectors, 640 busy cycles)
//  1. Ideal adder model, Start pulse -> Busy exactly 640 cycles, then Done=1, Pass=1, ErrCnt=0.
//  2. Model returns {Cout,S}=0 only for A=2,B=3,Cin=1 -> ErrCnt=1, FailA=2, FailB=3, FailCin=1,
//     FailS=0, Pass=0.
//  3. Vector boundaries: first Phase2 vector A=B=32'hFFFFFFFF,Cin=1 expects 33'h1_FFFFFFFF;
//     first Phase3 vector A=1,B=32'hFFFFFFFF,Cin=1 expects 33'h1_00000001; ideal model never flags.
//  4. Start re-pulsed at busy cycle 50 -> ignored, run still ends at cycle 640 with identical results.
//  5. Rst_n low at busy cycle 100 -> all outputs 0 asynchronously. After release, Start ->
//     first vector A=B=65530, Cin=1, Phase=0.
//  6. STOP_ON_FAIL build + fault of test 2 -> Done in that vector's CHECK cycle, ErrCnt=1,
//     A=2, B=3, Phase=1.

Source files
------------

// File: rtl/adder_bist_ctrl.sv
// Built-in self-test sequencer/checker for a WIDTH-bit adder: sweeps four operand phases,
// compares {Cout,S} against a full-width sum. Optional macro: ADDER_BIST_STOP_ON_FAIL_EN.
module adder_bist_ctrl #(
  parameter int WIDTH    = 32,
  parameter int SPAN     = 500,
  parameter int MID_BASE = 65530,
  parameter int SETTLE   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [1:0]       o_phase,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_cin,
  input  logic [WIDTH-1:0] i_s,
  input  logic             i_cout,
  output logic [15:0]      o_err_cnt,
  output logic [WIDTH-1:0] o_fail_a,
  output logic [WIDTH-1:0] o_fail_b,
  output logic             o_fail_cin,
  output logic [WIDTH:0]   o_fail_s,
  output logic [1:0]       o_state
);

  localparam int IW = (SPAN > 1) ? $clog2(SPAN) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(SPAN - 1);
  localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
  localparam logic [CW-1:0]    LAST_CNT = CW'(SETTLE - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MID      = WIDTH'(MID_BASE);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_a_idx;
  logic [IW-1:0]     r_b_idx;
  logic [1:0]        r_phase;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_cin;
  logic              r_pass;
  logic [15:0]       r_err_cnt;
  logic [WIDTH-1:0]  r_fail_a;
  logic [WIDTH-1:0]  r_fail_b;
  logic              r_fail_cin;
  logic [WIDTH:0]    r_fail_s;

  logic              w_start_ok;
  logic              w_settled;
  logic              w_last;
  logic              w_mismatch;
  logic              w_stop;
  logic              w_end;
  logic [1:0]        w_phase_nx;
  logic [WIDTH:0]    w_exp;
  logic [WIDTH:0]    w_obs;

  function automatic logic [WIDTH-1:0] a_start(input logic [1:0] ph);
    case (ph)
      2'd0:    a_start = MID;
      2'd1:    a_start = '0;
      2'd2:    a_start = ONES;
      default: a_start = ONE;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] b_start(input logic [1:0] ph);
    case (ph)
      2'd0:    b_start = MID;
      2'd1:    b_start = '0;
      default: b_start = ONES;
    endcase
  endfunction

  // Start is honoured only when no run is in flight.
  assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_settled  = (r_state == S_APPLY) && (r_cnt == LAST_CNT);
  assign w_last     = (r_phase == 2'd3) && (r_a_idx == LAST_IDX) &&
                      (r_b_idx == LAST_IDX) && !r_cin;
  assign w_exp      = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
  assign w_obs      = {i_cout, i_s};
  assign w_mismatch = (r_state == S_CHECK) && (w_exp != w_obs);
  assign w_phase_nx = r_phase + 2'd1;
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  assign w_stop     = w_mismatch;
`else
  assign w_stop     = 1'b0;
`endif
  assign w_end      = (r_state == S_CHECK) && (w_last || w_stop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_APPLY;
      S_APPLY: if (w_settled) w_next = S_CHECK;
      S_CHECK: w_next = w_end ? S_DONE : S_APPLY;
      S_DONE:  if (w_start_ok) w_next = S_APPLY;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (r_state == S_APPLY) || (r_state == S_CHECK);
    o_done  = (r_state == S_DONE);
    o_state = r_state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else if ((r_state == S_APPLY) && !w_settled) r_cnt <= r_cnt + CNT_ONE;
    else r_cnt <= '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase    <= '0;
      r_a_idx    <= '0;
      r_b_idx    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_cin      <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= '0;
      r_fail_a   <= '0;
      r_fail_b   <= '0;
      r_fail_cin <= 1'b0;
      r_fail_s   <= '0;
    end else if (w_start_ok) begin
      r_phase    <= 2'd0;
      r_a_idx    <= '0;
      r_b_idx    <= '0;
      r_a        <= MID;
      r_b        <= MID;
      r_cin      <= 1'b1;
      r_pass     <= 1'b0;
      r_err_cnt  <= '0;
      r_fail_a   <= '0;
      r_fail_b   <= '0;
      r_fail_cin <= 1'b0;
      r_fail_s   <= '0;
    end else if (r_state == S_CHECK) begin
      if (w_mismatch) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (r_err_cnt == 16'd0) begin
          r_fail_a   <= r_a;
          r_fail_b   <= r_b;
          r_fail_cin <= r_cin;
          r_fail_s   <= w_obs;
        end
      end
      // On the final (or aborting) vector the operands stay put.
      if (w_end) begin
        r_pass <= !w_mismatch && (r_err_cnt == 16'd0);
      end else if (r_cin) begin
        r_cin <= 1'b0;
      end else begin
        r_cin <= 1'b1;
        if (r_b_idx != LAST_IDX) begin
          r_b_idx <= r_b_idx + IDX_ONE;
          r_b     <= (r_phase[1]) ? (r_b - ONE) : (r_b + ONE);
        end else begin
          r_b_idx <= '0;
          if (r_a_idx != LAST_IDX) begin
            r_a_idx <= r_a_idx + IDX_ONE;
            r_a     <= (r_phase == 2'd2) ? (r_a - ONE) : (r_a + ONE);
            r_b     <= b_start(r_phase);
          end else begin
            r_a_idx <= '0;
            r_phase <= w_phase_nx;
            r_a     <= a_start(w_phase_nx);
            r_b     <= b_start(w_phase_nx);
          end
        end
      end
    end
  end

  assign o_pass     = r_pass;
  assign o_phase    = r_phase;
  assign o_a        = r_a;
  assign o_b        = r_b;
  assign o_cin      = r_cin;
  assign o_err_cnt  = r_err_cnt;
  assign o_fail_a   = r_fail_a;
  assign o_fail_b   = r_fail_b;
  assign o_fail_cin = r_fail_cin;
  assign o_fail_s   = r_fail_s;

endmodule
